// File: rtl/spi_pwm_regfile.sv
// spi_pwm_regfile
//   Register file that sits between spi_slave and the PWM array. It decodes a
//   command byte followed by 16-bit little-endian words. Each channel has a
//   freq and a duty_cycle_usec register. Reads and writes burst with channel
//   auto-increment.
//
// Ports
//   clk       system clock, all logic on posedge
//   rst       asynchronous active-high reset
//   ss        SPI select, active low, synchronous to clk
//   rx_avail  spi_slave byte-available flag; a rising edge marks a new byte
//   rx_byte   received byte, sampled in the cycle of the rising edge
//   tx_byte   next byte for miso (registered)
//   freq      per-channel frequency, channel i at [16*i +: 16]
//   duty      per-channel duty in usec, channel i at [16*i +: 16]
//   upd       one-cycle pulse per channel after its register commits
//   err_cnt   saturating count of rejected frames/words
module spi_pwm_regfile #(
  parameter int NUM_CH   = 4,
  parameter int FREQ_RST = 490,
  parameter int DUTY_RST = 1250
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ss,
  input  logic                   rx_avail,
  input  logic [7:0]             rx_byte,
  output logic [7:0]             tx_byte,
  output logic [16*NUM_CH-1:0]   freq,
  output logic [16*NUM_CH-1:0]   duty,
  output logic [NUM_CH-1:0]      upd,
  output logic [7:0]             err_cnt
);

  typedef enum logic [1:0] {IDLE, LO, HI, DROP} state_t;

  state_t            state, state_next;
  logic              rx_avail_q;
  logic              ev;
  logic [3:0]        ch, ch_next;
  logic              sel, sel_next;
  logic              wr, wr_next;
  logic [7:0]        lo, lo_next;
  logic [7:0]        tx_next;
  logic              err_inc;
  logic [NUM_CH-1:0] commit_freq, commit_duty;
  logic [15:0]       word;
  logic [3:0]        rd_ch;
  logic              rd_sel;
  logic [15:0]       rd_word;

  assign ev   = rx_avail & ~rx_avail_q;
  assign word = {rx_byte, lo};

  // Read address: in IDLE the command byte itself names the channel; in HI
  // the next channel is prefetched so a burst read streams without a gap.
  always_comb begin
    rd_ch  = ch;
    rd_sel = sel;
    if (state == IDLE) begin
      rd_ch  = rx_byte[3:0];
      rd_sel = rx_byte[4];
    end else if (state == HI) begin
      rd_ch = ch + 4'd1;
    end
  end

  // Channels that do not exist read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == 4'(i)) rd_word = rd_sel ? duty[16*i +: 16] : freq[16*i +: 16];
    end
  end

  always_comb begin
    state_next  = state;
    ch_next     = ch;
    sel_next    = sel;
    wr_next     = wr;
    lo_next     = lo;
    tx_next     = tx_byte;
    err_inc     = 1'b0;
    commit_freq = '0;
    commit_duty = '0;
    if (ss) begin
      // Deselect wins over a simultaneous byte and discards any half word.
      state_next = IDLE;
    end else if (ev) begin
      unique case (state)
        IDLE: begin
          if (rx_byte[7:6] != 2'b00) begin
            err_inc    = 1'b1;
            tx_next    = 8'h00;
            state_next = DROP;
          end else begin
            ch_next    = rx_byte[3:0];
            sel_next   = rx_byte[4];
            wr_next    = rx_byte[5];
            tx_next    = rx_byte[5] ? 8'h00 : rd_word[7:0];
            state_next = LO;
          end
        end
        LO: begin
          lo_next    = rx_byte;
          tx_next    = wr ? 8'h00 : rd_word[15:8];
          state_next = HI;
        end
        HI: begin
          ch_next    = ch + 4'd1;
          state_next = LO;
          if (!wr) begin
            tx_next = rd_word[7:0];
          end else begin
            tx_next = 8'h00;
            if (int'(ch) >= NUM_CH) begin
              err_inc = 1'b1;
            end else if (!sel && word == 16'h0000) begin
              err_inc = 1'b1;       // zero frequency is meaningless for the pwm
            end else begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (ch == 4'(i)) begin
                  if (sel) commit_duty[i] = 1'b1;
                  else     commit_freq[i] = 1'b1;
                end
              end
            end
          end
        end
        default: ;                  // DROP: wait for deselect
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rx_avail_q <= 1'b0;
      ch         <= 4'd0;
      sel        <= 1'b0;
      wr         <= 1'b0;
      lo         <= 8'h00;
      tx_byte    <= 8'h00;
      upd        <= '0;
      err_cnt    <= 8'h00;
    end else begin
      state      <= state_next;
      rx_avail_q <= rx_avail;
      ch         <= ch_next;
      sel        <= sel_next;
      wr         <= wr_next;
      lo         <= lo_next;
      tx_byte    <= tx_next;
      upd        <= commit_freq | commit_duty;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Per-channel registers load the whole word in one edge, so the pwm never
  // sees a half-updated value.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [15:0] freq_q, duty_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        freq_q <= 16'(FREQ_RST);
        duty_q <= 16'(DUTY_RST);
      end else begin
        if (commit_freq[gi]) freq_q <= word;
        if (commit_duty[gi]) duty_q <= word;
      end
    end
    assign freq[16*gi +: 16] = freq_q;
    assign duty[16*gi +: 16] = duty_q;
  end

endmodule
